// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       if_req_i,
    input  logic       d_rd_req_i,
    input  logic       d_wr_req_i,
    input  logic       mem_ready_i,
    output logic [1:0] addr_sel_o,
    output logic       mem_en_o,
    output logic       mem_we_o,
    output logic       if_gnt_o,
    output logic       d_gnt_o,
    output logic       stall_if_o,
    output logic       stall_mem_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_sel_q, addr_sel_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    logic       if_gnt, d_gnt;
    logic       d_req;
    logic       force_if;
    logic       decide;

    assign d_req  = d_rd_req_i | d_wr_req_i;
    assign if_gnt = (state_q == IF_ACC) & mem_ready_i;
    assign d_gnt  = (state_q == D_ACC) & mem_ready_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // The decision in a completing cycle must see this cycle's d_gnt, hence the _d compare.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    assign force_if = if_req_i & (starve_cnt_d == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        decide     = 1'b0;
        case (state_q)
            IDLE:    decide = 1'b1;
            IF_ACC:  decide = mem_ready_i;
            D_ACC:   decide = mem_ready_i;
            default: decide = 1'b1;
        endcase
        if (decide) begin
            if (force_if || (if_req_i && !d_req)) begin
                state_d    = IF_ACC;
                addr_sel_d = 2'b00;
                mem_en_d   = 1'b1;
                mem_we_d   = 1'b0;
            end else if (d_req) begin
                // Simultaneous rd and wr is treated as a write.
                state_d    = D_ACC;
                addr_sel_d = 2'b01;
                mem_en_d   = 1'b1;
                mem_we_d   = d_wr_req_i;
            end else begin
                state_d    = IDLE;
                addr_sel_d = 2'b00;
                mem_en_d   = 1'b0;
                mem_we_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_sel_q <= 2'b00;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign addr_sel_o  = addr_sel_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign stall_if_o  = if_req_i & ~if_gnt;
    assign stall_mem_o = d_req & ~d_gnt;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates the single-ported unified memory between the instruction-fetch (IF) requester and the MEM-stage data requester in the pipelined RISC-V core.
- Drives the 2-bit select of the 4-input address multiplexer in front of the memory, plus memory enable and write enable.
- Issues per-requester grant pulses and stall signals that freeze the IF or MEM stage while its access is pending.
- Sequences one access at a time with a small FSM and an optional starvation guard for instruction fetch.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants tolerated while IF is waiting before IF is forced ahead (starvation guard only).
- CNT_W, 3: starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  IF wants an instruction read; held high until if_gnt.
- d_rd_req  in  1  MEM stage wants a data read; held until d_gnt.
- d_wr_req  in  1  MEM stage wants a data write; held until d_gnt.
- mem_ready  in  1  memory completes the current access this cycle.
- addr_sel  out  2  address mux select: 2'b00 = PC (IF), 2'b01 = ALU result (data); 2'b10 and 2'b11 are never driven.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- if_gnt  out  1  one-cycle pulse: IF access done, instruction valid.
- d_gnt  out  1  one-cycle pulse: data access done.
- stall_if  out  1  = if_req & ~if_gnt.
- stall_mem  out  1  = (d_rd_req | d_wr_req) & ~d_gnt.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, IF_ACC, D_ACC.
- addr_sel, mem_en, mem_we are registered and decoded from the state:
  - IDLE: 00/0/0.
  - IF_ACC: 00/1/0.
  - D_ACC: 01/1/write_flag.
- Arbitration decision, evaluated in IDLE and at every completing cycle:
  - Default: a data request (rd or wr) wins over if_req.
  - Otherwise if_req goes to IF_ACC.
  - Otherwise the FSM returns to or stays in IDLE.
- Completion: in IF_ACC or D_ACC with mem_ready=1:
  - Pulse the matching gnt combinationally in the same cycle.
  - Transition directly to the next arbitrated state. No IDLE bubble between back-to-back accesses.
- In an access state with mem_ready=0: hold state and all outputs.
- write_flag is latched on entry to D_ACC.
- d_rd_req and d_wr_req high together (protocol violation): treated as a write, mem_we=1.
- A requester dropping its request mid-access does not abort the access. The access completes and the gnt pulse is still issued.
- Requests are sampled only at decision points. A request raised during another access waits for that access to complete.

## Timing
- Reset (asynchronous): state=IDLE, addr_sel=00, mem_en=0, mem_we=0, if_gnt=0, d_gnt=0, busy=0, starvation counter=0.
- Reset asserted mid-access aborts immediately. No gnt is issued for the aborted access.
- Latency, request seen in IDLE at edge N:
  - mem_en=1 during cycle N+1.
  - With a memory returning mem_ready=1 in its first cycle, gnt pulses in cycle N+1.
  - Minimum request-to-gnt is 1 cycle.
- Back-to-back throughput: one access per cycle while mem_ready stays high.
- stall_if and stall_mem are combinational. They fall in the gnt cycle so the stage advances on the same edge.

## Configuration
- ARB_STARVE_GUARD_EN defined: a CNT_W-bit counter is compiled in.
  - Increments (saturating) on each d_gnt while if_req=1.
  - Clears on if_gnt or whenever if_req=0.
  - When the counter equals STARVE_MAX, the next decision selects IF_ACC even if a data request is pending.
- ARB_STARVE_GUARD_EN undefined: no counter; strict data priority; IF can be starved indefinitely.

## Test plan
- Reset check: assert rst mid-D_ACC with mem_ready=0 -> all outputs 0 and state IDLE immediately, no d_gnt. Release rst with if_req=1 -> mem_en=1 and addr_sel=00 on the next cycle.
- Lone fetch: if_req=1, mem_ready tied 1 -> if_gnt pulses every cycle, addr_sel=00, mem_we=0, stall_if low on each gnt cycle.
- Simultaneous requests: if_req=1 and d_wr_req=1 in IDLE, mem_ready=1 -> first cycle D_ACC with addr_sel=01, mem_we=1, d_gnt=1. Next cycle IF_ACC with if_gnt=1. No idle cycle between them.
- Wait states: d_rd_req=1, mem_ready low for 3 cycles then high -> addr_sel=01 and mem_en=1 held 4 cycles, stall_mem high 3 cycles, d_gnt on cycle 4 only.
- Starvation, macro defined, STARVE_MAX=4: if_req and d_rd_req held high, mem_ready=1 -> 4 d_gnt pulses, then 1 if_gnt, then the pattern repeats.
- Starvation, macro undefined: same stimulus for 20 cycles -> 20 d_gnt pulses, zero if_gnt.
- Protocol violation: d_rd_req=1 and d_wr_req=1 together -> mem_we=1 for the whole access, single d_gnt.
